wb_stream_reader_sched: RTL and testbench
=========================================

// Module: wb_stream_reader_sched
// PURPOSE
//  Wishbone slave register bank and buffer sequencer for the stream-to-memory reader controller.
//  Software programs two buffer base addresses plus size and burst length, then starts the transfer.
//  The block pulses the controller's enable, tracks its busy, raises an interrupt per completed buffer
//  and, in continuous mode, ping-pongs between buffer 0 and buffer 1 without software intervention.
// PARAMETERS
//  WB_AW          32  address width (slave regs and controller config outputs)
//  WB_DW          32  data width
//  MAX_BURST_LEN  16  largest legal BURST_SIZE; larger values rejected at start
// PORTS
//  wb_clk_i    in   1        clock
//  wb_rst_i    in   1        reset, asynchronous, active-high
//  wb_adr_i    in   5        slave byte address; word index = wb_adr_i[4:2]
//  wb_dat_i    in   WB_DW    slave write data
//  wb_sel_i    in   WB_DW/8  byte enables (honoured per byte on RW regs)
//  wb_we_i     in   1        write strobe
//  wb_cyc_i    in   1        cycle
//  wb_stb_i    in   1        strobe
//  wb_cti_i    in   3        ignored (classic cycles only)
//  wb_bte_i    in   2        ignored
//  wb_dat_o    out  WB_DW    read data
//  wb_ack_o    out  1        ack
//  wb_err_o    out  1        tied 0
//  wb_rty_o    out  1        tied 0
//  enable      out  1        one-cycle start pulse to controller
//  busy        in   1        controller busy
//  tx_cnt      in   WB_DW    controller word counter (read-back only)
//  start_adr   out  WB_AW    latched base of active buffer
//  buf_size    out  WB_AW    latched buffer size, bytes
//  burst_size  out  WB_AW    latched burst length, words
//  irq         out  1        level interrupt = IRQ_PEND & IRQ_EN
// BEHAVIOUR
//  Registers (word idx): 0 CTRL RW b0 START(W1, self-clear) b1 CONT b2 IRQ_EN b3 STOP(W1, self-clear);
//   1 STATUS b0 busy(RO) b1 IRQ_PEND(W1C) b2 cur buffer(RO) b3 CFG_ERR(W1C) b4 running(RO);
//   2 ADR0 RW; 3 ADR1 RW; 4 BUF_SIZE RW; 5 BURST_SIZE RW; 6 TX_CNT RO; 7 DONE_CNT RO (wraps at 2^WB_DW).
//  Reset: all regs, outputs, FSM = 0 / IDLE; enable=0, wb_ack_o=0, irq=0. Reset mid-transfer abandons it.
//  Slave: ack registered, asserted 1 cycle after cyc&stb, held 1 cycle; never two acks for one strobe.
//   Write side effects take place on the acked cycle. Reads of RO regs return live values.
//  FSM: IDLE -> (START write, cfg valid) LAUNCH: latch start_adr=ADRn, buf_size, burst_size; enable=1 one cycle
//   -> WAIT_BUSY until busy=1 -> RUN until busy=0 -> DONE (1 cycle): IRQ_PEND=1, DONE_CNT+1;
//   if CONT & !stop_req: toggle buffer, -> LAUNCH; else -> IDLE, clear stop_req.
//  Cfg valid: BURST_SIZE!=0, BURST_SIZE<=MAX_BURST_LEN, BUF_SIZE[WB_AW-1:2]!=0, BUF_SIZE[WB_AW-1:2]
//   multiple of BURST_SIZE. Invalid on START: set CFG_ERR, stay IDLE, no enable pulse.
//  Cfg is revalidated at every ping-pong relaunch; invalid -> CFG_ERR, go IDLE.
//  First START always uses buffer 0; cur buffer resets to 0 on entering IDLE.
//  START while not IDLE ignored. STOP sets stop_req; current buffer completes, then IDLE. STOP in IDLE no-op.
//  Reg writes while running update regs only; outputs change only at LAUNCH latch.
//  IRQ_PEND set (DONE) and W1C in same cycle: set wins. CFG_ERR likewise.
//  Latency: START ack -> enable pulse 1 cycle later; busy fall -> irq 1 cycle later.
//  start_adr/buf_size/burst_size stable from LAUNCH until next LAUNCH.
// STRUCTURE
//  Shared pkg/include: register word-index localparams, CTRL/STATUS bit positions, FSM state encodings.
//  One sub-module natural: wb_stream_sched_regs (slave decode, ack, RW/W1C register file); FSM at top.
// TESTING
//  1 Reset: all regs read 0, irq=0; assert wb_rst_i mid-RUN -> enable/irq 0, STATUS.running=0 immediately.
//  2 ADR0=0x1000, BUF_SIZE=64, BURST=4, START -> one enable pulse, start_adr=0x1000; busy 1->0 -> IRQ_PEND=1,
//    DONE_CNT=1, FSM IDLE; W1C STATUS b1 -> irq=0.
//  3 CONT=1, ADR0=0x1000, ADR1=0x2000: three busy cycles -> start_adr 0x1000,0x2000,0x1000, DONE_CNT=3;
//    STOP during 3rd -> IDLE after 3rd done.
//  4 BURST=0, or BURST=17, or BUF_SIZE=60 with BURST=4 -> START gives CFG_ERR=1, no enable pulse.
//  5 Rewrite ADR1=0x3000 during RUN on buffer 0 -> start_adr stays 0x1000 until relaunch, then 0x3000.
//  6 DONE and W1C of IRQ_PEND same cycle -> IRQ_PEND stays 1; START while RUN -> ignored, no 2nd pulse.

Source files
------------

// File: rtl/wb_stream_reader_sched_pkg.sv
// Shared definitions for the stream reader scheduler:
// register map, CTRL/STATUS bit positions, FSM states.
package wb_stream_reader_sched_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_ADR0   = 3'd2;
  localparam logic [2:0] REG_ADR1   = 3'd3;
  localparam logic [2:0] REG_BUF    = 3'd4;
  localparam logic [2:0] REG_BURST  = 3'd5;
  localparam logic [2:0] REG_TXCNT  = 3'd6;
  localparam logic [2:0] REG_DONE   = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_PEND = 1;
  localparam int ST_CUR  = 2;
  localparam int ST_ERR  = 3;
  localparam int ST_RUN  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/wb_stream_sched_regs.sv
// Wishbone classic slave: decode, registered ack,
// RW/W1C register file and done counter.
module wb_stream_sched_regs
  import wb_stream_reader_sched_pkg::*;
#(
  parameter int WB_DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         i_idx,
  input  logic [WB_DW-1:0]   i_dat,
  input  logic [WB_DW/8-1:0] i_sel,
  input  logic               i_we,
  input  logic               i_cyc,
  input  logic               i_stb,
  output logic [WB_DW-1:0]   o_dat,
  output logic               o_ack,
  input  logic               i_busy,
  input  logic               i_running,
  input  logic               i_cur,
  input  logic               i_irq_set,
  input  logic               i_err_set,
  input  logic               i_done,
  input  logic [WB_DW-1:0]   i_tx_cnt,
  output logic               o_start,
  output logic               o_stop,
  output logic               o_cont,
  output logic               o_irq_en,
  output logic               o_irq_pend,
  output logic [WB_DW-1:0]   o_adr0,
  output logic [WB_DW-1:0]   o_adr1,
  output logic [WB_DW-1:0]   o_buf_size,
  output logic [WB_DW-1:0]   o_burst
);

  logic             r_ack;
  logic             r_cont;
  logic             r_irq_en;
  logic             r_pend;
  logic             r_err;
  logic [WB_DW-1:0] r_adr0;
  logic [WB_DW-1:0] r_adr1;
  logic [WB_DW-1:0] r_buf;
  logic [WB_DW-1:0] r_burst;
  logic [WB_DW-1:0] r_done_cnt;

  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_st_wr;
  logic [WB_DW-1:0] w_status;

  function automatic logic [WB_DW-1:0] merge(
    input logic [WB_DW-1:0]   old,
    input logic [WB_DW-1:0]   d,
    input logic [WB_DW/8-1:0] s
  );
    logic [WB_DW-1:0] r;
    r = old;
    for (int b = 0; b < WB_DW/8; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Side effects land on the acked cycle only
  assign w_wr      = r_ack & i_cyc & i_stb & i_we;
  assign w_ctrl_wr = w_wr & (i_idx == REG_CTRL) & i_sel[0];
  assign w_st_wr   = w_wr & (i_idx == REG_STATUS) & i_sel[0];
  assign o_start   = w_ctrl_wr & i_dat[CTRL_START];
  assign o_stop    = w_ctrl_wr & i_dat[CTRL_STOP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_cont     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
      r_adr0     <= '0;
      r_adr1     <= '0;
      r_buf      <= '0;
      r_burst    <= '0;
      r_done_cnt <= '0;
    end else begin
      r_ack <= i_cyc & i_stb & ~r_ack;
      if (w_ctrl_wr) begin
        r_cont   <= i_dat[CTRL_CONT];
        r_irq_en <= i_dat[CTRL_IRQEN];
      end
      if (i_irq_set)
        r_pend <= 1'b1;
      else if (w_st_wr && i_dat[ST_PEND])
        r_pend <= 1'b0;
      if (i_err_set)
        r_err <= 1'b1;
      else if (w_st_wr && i_dat[ST_ERR])
        r_err <= 1'b0;
      if (i_done)
        r_done_cnt <= r_done_cnt + WB_DW'(1);
      if (w_wr) begin
        case (i_idx)
          REG_ADR0:  r_adr0  <= merge(r_adr0, i_dat, i_sel);
          REG_ADR1:  r_adr1  <= merge(r_adr1, i_dat, i_sel);
          REG_BUF:   r_buf   <= merge(r_buf, i_dat, i_sel);
          REG_BURST: r_burst <= merge(r_burst, i_dat, i_sel);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[ST_BUSY] = i_busy;
    w_status[ST_PEND] = r_pend;
    w_status[ST_CUR]  = i_cur;
    w_status[ST_ERR]  = r_err;
    w_status[ST_RUN]  = i_running;
  end

  always_comb begin
    o_dat = '0;
    if (r_ack) begin
      case (i_idx)
        REG_CTRL: begin
          o_dat[CTRL_CONT]  = r_cont;
          o_dat[CTRL_IRQEN] = r_irq_en;
        end
        REG_STATUS: o_dat = w_status;
        REG_ADR0:   o_dat = r_adr0;
        REG_ADR1:   o_dat = r_adr1;
        REG_BUF:    o_dat = r_buf;
        REG_BURST:  o_dat = r_burst;
        REG_TXCNT:  o_dat = i_tx_cnt;
        REG_DONE:   o_dat = r_done_cnt;
        default:    o_dat = '0;
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_cont     = r_cont;
  assign o_irq_en   = r_irq_en;
  assign o_irq_pend = r_pend;
  assign o_adr0     = r_adr0;
  assign o_adr1     = r_adr1;
  assign o_buf_size = r_buf;
  assign o_burst    = r_burst;

endmodule

// File: rtl/wb_stream_reader_sched.sv
// Buffer sequencer for the stream-to-memory reader:
// launches the controller, tracks busy, ping-pongs buffers.
module wb_stream_reader_sched
  import wb_stream_reader_sched_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_DW/8-1:0] wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic               enable,
  input  logic               busy,
  input  logic [WB_DW-1:0]   tx_cnt,
  output logic [WB_AW-1:0]   start_adr,
  output logic [WB_AW-1:0]   buf_size,
  output logic [WB_AW-1:0]   burst_size,
  output logic               irq
);

  state_t           r_state;
  logic             r_enable;
  logic             r_cur;
  logic             r_stop_req;
  logic [WB_AW-1:0] r_start_adr;
  logic [WB_AW-1:0] r_buf_size;
  logic [WB_AW-1:0] r_burst_size;

  logic             w_start;
  logic             w_stop;
  logic             w_cont;
  logic             w_irq_en;
  logic             w_pend;
  logic [WB_DW-1:0] w_adr0;
  logic [WB_DW-1:0] w_adr1;
  logic [WB_DW-1:0] w_buf;
  logic [WB_DW-1:0] w_burst;
  logic [WB_AW-1:0] w_adr0_a;
  logic [WB_AW-1:0] w_adr1_a;
  logic [WB_AW-1:0] w_buf_a;
  logic [WB_AW-1:0] w_burst_a;
  logic [WB_AW-1:0] w_words;
  logic             w_cfg_ok;
  logic             w_running;
  logic             w_done;
  logic             w_relaunch;
  logic             w_err_set;
  logic             w_unused;

  wb_stream_sched_regs #(
    .WB_DW (WB_DW)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .i_idx      (wb_adr_i[4:2]),
    .i_dat      (wb_dat_i),
    .i_sel      (wb_sel_i),
    .i_we       (wb_we_i),
    .i_cyc      (wb_cyc_i),
    .i_stb      (wb_stb_i),
    .o_dat      (wb_dat_o),
    .o_ack      (wb_ack_o),
    .i_busy     (busy),
    .i_running  (w_running),
    .i_cur      (r_cur),
    .i_irq_set  (w_done),
    .i_err_set  (w_err_set),
    .i_done     (w_done),
    .i_tx_cnt   (tx_cnt),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_cont     (w_cont),
    .o_irq_en   (w_irq_en),
    .o_irq_pend (w_pend),
    .o_adr0     (w_adr0),
    .o_adr1     (w_adr1),
    .o_buf_size (w_buf),
    .o_burst    (w_burst)
  );

  assign w_adr0_a  = WB_AW'(w_adr0);
  assign w_adr1_a  = WB_AW'(w_adr1);
  assign w_buf_a   = WB_AW'(w_buf);
  assign w_burst_a = WB_AW'(w_burst);
  assign w_words   = {2'b00, w_buf_a[WB_AW-1:2]};

  // Buffer must hold a whole number of legal bursts
  assign w_cfg_ok = (w_burst_a != '0)
                 && (w_burst_a <= WB_AW'(MAX_BURST_LEN))
                 && (w_words != '0)
                 && ((w_words % w_burst_a) == '0);

  assign w_running  = (r_state != S_IDLE);
  assign w_done     = (r_state == S_RUN) & ~busy;
  assign w_relaunch = w_cont & ~(r_stop_req | w_stop);
  assign w_err_set  = ((r_state == S_IDLE) & w_start & ~w_cfg_ok)
                    | ((r_state == S_DONE) & w_relaunch & ~w_cfg_ok);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_enable     <= 1'b0;
      r_cur        <= 1'b0;
      r_stop_req   <= 1'b0;
      r_start_adr  <= '0;
      r_buf_size   <= '0;
      r_burst_size <= '0;
    end else begin
      r_enable <= 1'b0;
      if (w_stop && r_state != S_IDLE)
        r_stop_req <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start && w_cfg_ok) begin
            r_state      <= S_LAUNCH;
            r_enable     <= 1'b1;
            r_cur        <= 1'b0;
            r_start_adr  <= w_adr0_a;
            r_buf_size   <= w_buf_a;
            r_burst_size <= w_burst_a;
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT:   if (busy) r_state <= S_RUN;
        S_RUN:    if (!busy) r_state <= S_DONE;
        S_DONE: begin
          if (w_relaunch && w_cfg_ok) begin
            r_state      <= S_LAUNCH;
            r_enable     <= 1'b1;
            r_cur        <= ~r_cur;
            r_start_adr  <= r_cur ? w_adr0_a : w_adr1_a;
            r_buf_size   <= w_buf_a;
            r_burst_size <= w_burst_a;
          end else begin
            r_state    <= S_IDLE;
            r_cur      <= 1'b0;
            r_stop_req <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign enable     = r_enable;
  assign start_adr  = r_start_adr;
  assign buf_size   = r_buf_size;
  assign burst_size = r_burst_size;
  assign irq        = w_pend & w_irq_en;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign w_unused   = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_stream_reader_sched.sv
// Directed bench for the stream reader scheduler with
// scoreboards for register reads and launch addresses.
module tb_wb_stream_reader_sched;
  import wb_stream_reader_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;
  logic        enable;
  logic        busy = 1'b0;
  logic [31:0] tx_cnt = '0;
  logic [31:0] start_adr;
  logic [31:0] buf_size;
  logic [31:0] burst_size;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int n_en = 0;
  logic [31:0] q_en[$];
  logic [31:0] q_rd[$];

  wb_stream_reader_sched dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_i),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_cti_i   (cti),
    .wb_bte_i   (bte),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .enable     (enable),
    .busy       (busy),
    .tx_cnt     (tx_cnt),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Each launch must match the next address queued by the bench
  always @(negedge clk) begin
    if (!rst && enable) begin
      n_en++;
      check("en_expected", 32'(q_en.size() != 0), 32'd1);
      if (q_en.size() != 0)
        check("start_adr", start_adr, q_en.pop_front());
    end
  end

  task automatic wb_cycle(input logic [2:0] idx, input logic w,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd);
    int n;
    logic seen;
    rd = '0;
    seen = 1'b0;
    n = 0;
    @(posedge clk); #1;
    adr = {idx, 2'b00}; dat_i = d; sel = s; we = w; cyc = 1; stb = 1;
    while (!seen && n < 8) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        rd = dat_o;
      end
      n++;
    end
    check("wb_ack", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check("wb_single_ack", {31'b0, ack}, 32'd0);
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d,
                          input logic [3:0] s = 4'hF);
    logic [31:0] dummy;
    wb_cycle(idx, 1'b1, d, s, dummy);
  endtask

  task automatic wb_read(input logic [2:0] idx, input logic [31:0] exp,
                         input string tag);
    logic [31:0] rd;
    q_rd.push_back(exp);
    wb_cycle(idx, 1'b0, '0, 4'h0, rd);
    check(tag, rd, q_rd.pop_front());
  endtask

  task automatic wait_en(input int n);
    int k;
    k = 0;
    while (n_en < n && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("wait_en", 32'(n_en), 32'(n));
  endtask

  task automatic busy_pulse(input int len);
    @(posedge clk); #1 busy = 1'b1;
    repeat (len) @(posedge clk);
    #1 busy = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1; n_en = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic program_cfg();
    wb_write(REG_ADR0, 32'h1000);
    wb_write(REG_ADR1, 32'h2000);
    wb_write(REG_BUF, 32'd64);
    wb_write(REG_BURST, 32'd4);
  endtask

  logic [31:0] bad_buf[3] = '{32'd64, 32'd64, 32'd60};
  logic [31:0] bad_bst[3] = '{32'd0, 32'd17, 32'd4};

  initial begin
    repeat (3) @(posedge clk);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_enable", {31'b0, enable}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++)
      wb_read(3'(i), 32'h0, "rst_reg");

    // single buffer
    wb_write(REG_ADR0, 32'h1000);
    wb_write(REG_BUF, 32'd64);
    wb_write(REG_BURST, 32'd4);
    q_en.push_back(32'h1000);
    wb_write(REG_CTRL, 32'h5);
    wait_en(1);
    check("buf_size", buf_size, 32'd64);
    check("burst_size", burst_size, 32'd4);
    busy_pulse(4);
    @(negedge clk);
    check("irq_early", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_latency", {31'b0, irq}, 32'd1);
    wb_read(REG_STATUS, 32'h2, "status_done");
    wb_read(REG_DONE, 32'd1, "done_cnt1");
    tx_cnt = 32'hCAFE_0010;
    wb_read(REG_TXCNT, 32'hCAFE_0010, "tx_cnt");
    wb_write(REG_STATUS, 32'h2);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    wb_read(REG_STATUS, 32'h0, "status_clr");
    wb_read(REG_CTRL, 32'h4, "ctrl_selfclr");

    // invalid configurations
    for (int i = 0; i < 3; i++) begin
      wb_write(REG_BUF, bad_buf[i]);
      wb_write(REG_BURST, bad_bst[i]);
      wb_write(REG_CTRL, 32'h5);
      wb_read(REG_STATUS, 32'h8, "cfg_err");
      wb_write(REG_STATUS, 32'h8);
      wb_read(REG_STATUS, 32'h0, "cfg_err_clr");
    end
    check("no_en_bad_cfg", 32'(n_en), 32'd1);

    // byte enables, then largest legal burst
    wb_write(REG_ADR0, 32'h1234_5678);
    wb_write(REG_ADR0, 32'hAABB_CCDD, 4'b0100);
    wb_read(REG_ADR0, 32'h12BB_5678, "byte_sel");
    wb_write(REG_ADR0, 32'h1000);
    wb_write(REG_BUF, 32'd64);
    wb_write(REG_BURST, 32'd16);
    q_en.push_back(32'h1000);
    wb_write(REG_CTRL, 32'h5);
    wait_en(2);
    check("burst_max", burst_size, 32'd16);
    busy_pulse(3);
    repeat (3) @(posedge clk);
    wb_read(REG_STATUS, 32'h2, "status_max");

    // continuous ping-pong with stop on third buffer
    reset_dut();
    program_cfg();
    q_en.push_back(32'h1000);
    q_en.push_back(32'h2000);
    q_en.push_back(32'h1000);
    wb_write(REG_CTRL, 32'h7);
    wait_en(1);
    busy_pulse(4);
    wait_en(2);
    @(posedge clk); #1 busy = 1'b1;
    wb_read(REG_STATUS, 32'h17, "status_buf1");
    #1 busy = 1'b0;
    wait_en(3);
    @(posedge clk); #1 busy = 1'b1;
    wb_write(REG_CTRL, 32'hE);
    repeat (2) @(posedge clk);
    #1 busy = 1'b0;
    repeat (10) @(posedge clk);
    check("stop_no_relaunch", 32'(n_en), 32'd3);
    wb_read(REG_STATUS, 32'h2, "status_stopped");
    wb_read(REG_DONE, 32'd3, "done_cnt3");
    wb_read(REG_CTRL, 32'h6, "ctrl_after_stop");

    // live rewrite, start while running, DONE vs W1C
    reset_dut();
    program_cfg();
    q_en.push_back(32'h1000);
    q_en.push_back(32'h3000);
    wb_write(REG_CTRL, 32'h7);
    wait_en(1);
    @(posedge clk); #1 busy = 1'b1;
    wb_write(REG_ADR1, 32'h3000);
    wb_write(REG_CTRL, 32'h7);
    check("adr_hold", start_adr, 32'h1000);
    wb_read(REG_ADR1, 32'h3000, "adr1_rw");
    @(posedge clk); #1;
    adr = {REG_STATUS, 2'b00}; dat_i = 32'h2; sel = 4'hF;
    we = 1; cyc = 1; stb = 1;
    @(posedge clk); #1 busy = 1'b0;
    @(negedge clk);
    check("w1c_ack", {31'b0, ack}, 32'd1);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    wait_en(2);
    wb_read(REG_STATUS, 32'h16, "pend_set_wins");
    @(posedge clk); #1 busy = 1'b1;
    wb_write(REG_CTRL, 32'hE);
    #1 busy = 1'b0;
    repeat (10) @(posedge clk);
    check("start_ignored", 32'(n_en), 32'd2);
    check("irq_high", {31'b0, irq}, 32'd1);

    // asynchronous reset mid-run
    q_en.push_back(32'h1000);
    wb_write(REG_CTRL, 32'h5);
    wait_en(3);
    @(posedge clk); #1 busy = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_irq", {31'b0, irq}, 32'd0);
    check("midrst_enable", {31'b0, enable}, 32'd0);
    busy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    wb_read(REG_STATUS, 32'h0, "midrst_status");
    wb_read(REG_CTRL, 32'h0, "midrst_ctrl");
    wb_read(REG_DONE, 32'h0, "midrst_done");
    check("q_en_empty", 32'(q_en.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
